issue_queue_free_list: RTL and testbench



---
 rtl/issue_queue_free_list.sv | 166 ++++++++++++++++
 tb/tb_issue_queue_free_list.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue_free_list.sv
// Circular free list of issue-queue entry indices: dispatch pops, release lanes and a flush-drain FSM push.
// Optional protocol checking is enabled with `define RSD_IQ_FREE_LIST_CHECK_EN.
module issue_queue_free_list #(
  parameter  int ISSUE_QUEUE_ENTRY_NUM = 16,
  parameter  int DISPATCH_WIDTH        = 2,
  parameter  int RELEASE_WIDTH         = 4,
  localparam int IDX_W                 = $clog2(ISSUE_QUEUE_ENTRY_NUM)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stall,
  input  logic [DISPATCH_WIDTH-1:0]        allocate,
  output logic [IDX_W-1:0]                 allocPtr [DISPATCH_WIDTH],
  output logic                             allocatable,
  input  logic [RELEASE_WIDTH-1:0]         releaseEntry,
  input  logic [IDX_W-1:0]                 releasePtr [RELEASE_WIDTH],
  input  logic [ISSUE_QUEUE_ENTRY_NUM-1:0] flushIQ_Entry,
  input  logic                             flushValid,
  output logic                             drainBusy,
  output logic [IDX_W:0]                   freeCount,
  output logic                             error
);

  localparam int CNT_W = IDX_W + 1;
  localparam int SUM_W = $clog2(ISSUE_QUEUE_ENTRY_NUM + RELEASE_WIDTH + 1) + 1;

  typedef enum logic {IDLE, DRAIN} drain_state_e;

  logic [IDX_W-1:0]                 entry_q [ISSUE_QUEUE_ENTRY_NUM];
  logic [IDX_W-1:0]                 head_q, tail_q;
  logic [CNT_W-1:0]                 count_q;
  logic [ISSUE_QUEUE_ENTRY_NUM-1:0] pending_q, pending_d;
  drain_state_e                     state_q, state_d;

  logic [SUM_W-1:0]                 pop_req, pop_n, room, rel_cnt, push_n, push_acc, count_next;
  logic [SUM_W-1:0]                 rel_slot [RELEASE_WIDTH];
  logic [RELEASE_WIDTH-1:0]         rel_acc;
  logic                             drain_valid, drain_acc;
  logic [ISSUE_QUEUE_ENTRY_NUM-1:0] drain_bit;
  logic [IDX_W-1:0]                 drain_idx;

  assign allocatable = (count_q >= CNT_W'(DISPATCH_WIDTH));
  assign drainBusy   = |pending_q;
  assign freeCount   = count_q;

  // Grants come straight from storage; entries pushed this cycle are not visible until next cycle.
  always_comb begin
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      allocPtr[i] = entry_q[IDX_W'(head_q + IDX_W'(i))];
    end
  end

  always_comb begin
    pop_req = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      pop_req = pop_req + SUM_W'(allocate[i]);
    end
    pop_n = (!stall && allocatable) ? pop_req : '0;
  end

  // Drain candidate: lowest pending bit, isolated by two's-complement masking.
  always_comb begin
    drain_valid = (state_q == DRAIN) && (|pending_q);
    drain_bit   = pending_q & (~pending_q + ISSUE_QUEUE_ENTRY_NUM'(1));
    drain_idx   = '0;
    for (int b = 0; b < ISSUE_QUEUE_ENTRY_NUM; b++) begin
      if (drain_bit[b]) drain_idx = IDX_W'(b);
    end
  end

  // NOTE: rel_cnt is a running sum inside one combinational pass, so blocking assignment is
  // required here; every output gets a default first so no latch is inferred.
  always_comb begin
    rel_cnt = '0;
    for (int i = 0; i < RELEASE_WIDTH; i++) begin
      rel_slot[i] = rel_cnt;
      if (releaseEntry[i]) rel_cnt = rel_cnt + SUM_W'(1);
    end
    push_n = rel_cnt + SUM_W'(drain_valid);
    room   = SUM_W'(ISSUE_QUEUE_ENTRY_NUM) - SUM_W'(count_q) + pop_n;
    for (int i = 0; i < RELEASE_WIDTH; i++) begin
      rel_acc[i] = releaseEntry[i] && (rel_slot[i] < room);
    end
    drain_acc  = drain_valid && (rel_cnt < room);
    // Pushes beyond the free space are dropped so the count saturates at ENTRY_NUM.
    push_acc   = (push_n > room) ? room : push_n;
    count_next = SUM_W'(count_q) - pop_n + push_acc;
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    unique case (state_q)
      IDLE: begin
        if (flushValid) begin
          pending_d = pending_q | flushIQ_Entry;
          if (pending_d != '0) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The bit being pushed this cycle is cleared even if the new flush vector sets it again.
        pending_d = (pending_q | (flushValid ? flushIQ_Entry : '0)) & ~drain_bit;
        if (pending_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // NOTE: the storage must be reset because its initial contents (k at slot k) are the free list itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < ISSUE_QUEUE_ENTRY_NUM; k++) begin
        entry_q[k] <= IDX_W'(k);
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CNT_W'(ISSUE_QUEUE_ENTRY_NUM);
    end else begin
      for (int i = 0; i < RELEASE_WIDTH; i++) begin
        if (rel_acc[i]) entry_q[IDX_W'(tail_q + IDX_W'(rel_slot[i]))] <= releasePtr[i];
      end
      if (drain_acc) entry_q[IDX_W'(tail_q + IDX_W'(rel_cnt))] <= drain_idx;
      head_q  <= head_q + IDX_W'(pop_n);
      tail_q  <= tail_q + IDX_W'(push_acc);
      count_q <= CNT_W'(count_next);
    end
  end

`ifdef RSD_IQ_FREE_LIST_CHECK_EN
  logic error_q, dup_ptr, protocol_err;

  always_comb begin
    dup_ptr = 1'b0;
    for (int i = 0; i < RELEASE_WIDTH; i++) begin
      for (int j = i + 1; j < RELEASE_WIDTH; j++) begin
        if (releaseEntry[i] && releaseEntry[j] && (releasePtr[i] == releasePtr[j])) dup_ptr = 1'b1;
      end
      if (releaseEntry[i] && drain_valid && (releasePtr[i] == drain_idx)) dup_ptr = 1'b1;
    end
    protocol_err = (push_n > room)
                || ((|allocate) && !allocatable && !stall)
                || ((allocate & (allocate + DISPATCH_WIDTH'(1))) != '0)
                || dup_ptr;
  end

  always_ff @(posedge clk) begin
    if (rst)               error_q <= 1'b0;
    else if (protocol_err) error_q <= 1'b1;
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_issue_queue_free_list.sv
// Scoreboard bench for issue_queue_free_list: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_issue_queue_free_list;

  localparam int N  = 16;
  localparam int DW = 2;
  localparam int RW = 4;
  localparam int IW = 4;

`ifdef RSD_IQ_FREE_LIST_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic [DW-1:0] allocate;
  logic [IW-1:0] allocPtr [DW];
  logic          allocatable;
  logic [RW-1:0] releaseEntry;
  logic [IW-1:0] releasePtr [RW];
  logic [N-1:0]  flushIQ_Entry;
  logic          flushValid;
  logic          drainBusy;
  logic [IW:0]   freeCount;
  logic          error;

  issue_queue_free_list #(
    .ISSUE_QUEUE_ENTRY_NUM(N),
    .DISPATCH_WIDTH(DW),
    .RELEASE_WIDTH(RW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .allocate(allocate),
    .allocPtr(allocPtr),
    .allocatable(allocatable),
    .releaseEntry(releaseEntry),
    .releasePtr(releasePtr),
    .flushIQ_Entry(flushIQ_Entry),
    .flushValid(flushValid),
    .drainBusy(drainBusy),
    .freeCount(freeCount),
    .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    cyc;
    bit    chk_ptr;
    int    p0;
    int    p1;
    int    fc;
    bit    aok;
    bit    busy;
    bit    err;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
      check({e.name, "_freeCount"}, 32'(freeCount), 32'(e.fc));
      check({e.name, "_allocatable"}, 32'(allocatable), 32'(e.aok));
      check({e.name, "_drainBusy"}, 32'(drainBusy), 32'(e.busy));
      check({e.name, "_error"}, 32'(error), 32'(e.err));
      if (e.chk_ptr) begin
        check({e.name, "_allocPtr0"}, 32'(allocPtr[0]), 32'(e.p0));
        check({e.name, "_allocPtr1"}, 32'(allocPtr[1]), 32'(e.p1));
      end
    end
  end

  task automatic expect_out(input string name, input bit chk_ptr, input int p0, input int p1,
                            input int fc, input bit aok, input bit busy, input bit err);
    exp_t e;
    e.name = name; e.cyc = cyc; e.chk_ptr = chk_ptr; e.p0 = p0; e.p1 = p1;
    e.fc = fc; e.aok = aok; e.busy = busy; e.err = err;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rel(input logic [RW-1:0] en, input int a, input int b, input int c, input int d);
    releaseEntry  = en;
    releasePtr[0] = IW'(a);
    releasePtr[1] = IW'(b);
    releasePtr[2] = IW'(c);
    releasePtr[3] = IW'(d);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; allocate = '0; flushValid = 1'b0; flushIQ_Entry = '0;
    set_rel(4'b0000, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state, then drain the whole list in pairs.
    expect_out("reset", 1, 0, 1, 16, 1, 0, 0);
    tick();
    allocate = 2'b11;
    for (int j = 0; j < 8; j++) begin
      expect_out($sformatf("pop%0d", j), 1, 2 * j, 2 * j + 1, 16 - 2 * j, 1, 0, 0);
      tick();
    end
    allocate = 2'b00;

    // Four releases into an empty list, granted back in lane order.
    set_rel(4'b1111, 5, 9, 2, 7);
    expect_out("empty", 0, 0, 0, 0, 0, 0, 0);
    tick();
    set_rel(4'b0000, 0, 0, 0, 0);
    allocate = 2'b11;
    expect_out("rel_pop0", 1, 5, 9, 4, 1, 0, 0);
    tick();
    expect_out("rel_pop1", 1, 2, 7, 2, 1, 0, 0);
    tick();

    // Simultaneous pop and sparse release with count = 4.
    allocate = 2'b00;
    set_rel(4'b1111, 1, 3, 4, 6);
    expect_out("refill", 0, 0, 0, 0, 0, 0, 0);
    tick();
    set_rel(4'b1101, 8, 11, 12, 13);
    allocate = 2'b11;
    expect_out("pop_push", 1, 1, 3, 4, 1, 0, 0);
    tick();
    set_rel(4'b0000, 0, 0, 0, 0);
    expect_out("no_bypass", 1, 4, 6, 5, 1, 0, 0);
    tick();
    expect_out("compact", 1, 8, 12, 3, 1, 0, 0);
    tick();
    allocate = 2'b00;
    set_rel(4'b0001, 14, 0, 0, 0);
    expect_out("one_left", 0, 0, 0, 1, 0, 0, 0);
    tick();
    set_rel(4'b0000, 0, 0, 0, 0);
    allocate = 2'b11;
    expect_out("last_pair", 1, 13, 14, 2, 1, 0, 0);
    tick();

    // Flush drain from empty, with a second flush arriving mid-drain.
    allocate = 2'b00;
    flushValid = 1'b1; flushIQ_Entry = 16'h0421;
    expect_out("flush_sample", 0, 0, 0, 0, 0, 0, 0);
    tick();
    flushValid = 1'b0;
    expect_out("drain1", 0, 0, 0, 0, 0, 1, 0);
    tick();
    flushValid = 1'b1; flushIQ_Entry = 16'h0002;
    expect_out("drain2", 0, 0, 0, 1, 0, 1, 0);
    tick();
    flushValid = 1'b0;
    expect_out("drain3", 1, 0, 5, 2, 1, 1, 0);
    tick();
    expect_out("drain4", 1, 0, 5, 3, 1, 1, 0);
    tick();
    allocate = 2'b11;
    expect_out("drain_done", 1, 0, 5, 4, 1, 0, 0);
    tick();
    expect_out("drain_order", 1, 1, 10, 2, 1, 0, 0);
    tick();

    // Reset in the middle of a drain with count = 3.
    allocate = 2'b00;
    set_rel(4'b0111, 2, 3, 4, 0);
    expect_out("pre_rst", 0, 0, 0, 0, 0, 0, 0);
    tick();
    set_rel(4'b0000, 0, 0, 0, 0);
    flushValid = 1'b1; flushIQ_Entry = 16'h00F0;
    expect_out("rst_flush", 0, 0, 0, 3, 1, 0, 0);
    tick();
    flushValid = 1'b0;
    rst = 1'b1;
    expect_out("rst_in_drain", 0, 0, 0, 3, 1, 1, 0);
    tick();
    rst = 1'b0;
    expect_out("after_rst", 1, 0, 1, 16, 1, 0, 0);
    tick();
    expect_out("no_resume", 1, 0, 1, 16, 1, 0, 0);
    tick();

    // Release while full: discarded, sticky error only in the checking build.
    set_rel(4'b0001, 3, 0, 0, 0);
    expect_out("full_push", 0, 0, 0, 16, 1, 0, 0);
    tick();
    set_rel(4'b0000, 0, 0, 0, 0);
    expect_out("err_set", 0, 0, 0, 16, 1, 0, CHK);
    tick();
    stall = 1'b1; allocate = 2'b11;
    expect_out("stall", 1, 0, 1, 16, 1, 0, CHK);
    tick();
    stall = 1'b0; allocate = 2'b00;
    expect_out("err_sticky", 1, 0, 1, 16, 1, 0, CHK);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_out("err_clear", 1, 0, 1, 16, 1, 0, 0);
    tick();
    tick();

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
